// File: rtl/op_stack.sv
// op_stack: operator stack for the expression controller.
// Pushed operator codes are taken from the shared tri-state bus. The top entry
// is driven back onto the same bus for pop and top reads. The block reports
// empty, full, count and a sticky error flag for overflow and underflow.

`ifndef CO_N
`define CO_N 4
`endif
`ifndef CO_NO
`define CO_NO 4'd0
`endif
`ifndef CO_AD
`define CO_AD 4'd1
`endif
`ifndef CO_SB
`define CO_SB 4'd2
`endif
`ifndef SC_N
`define SC_N 3
`endif
`ifndef SC_NON
`define SC_NON 3'd0
`endif
`ifndef SC_PUS
`define SC_PUS 3'd1
`endif
`ifndef SC_POP
`define SC_POP 3'd2
`endif
`ifndef SC_TOP
`define SC_TOP 3'd3
`endif
`ifndef SC_CLR
`define SC_CLR 3'd4
`endif

module op_stack #(
    parameter int WIDTH = `CO_N,
    parameter int DEPTH = 16,
    parameter int PTR_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [`SC_N-1:0] i_op_cmd,
    inout  wire  [WIDTH-1:0] io_op_data,
    output logic             o_op_empty,
    output logic             o_op_full,
    output logic [PTR_W-1:0] o_op_count,
    output logic             o_op_err
);

    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] SP_FULL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] SP_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_sp;
    logic             r_err;

    logic             w_push;
    logic             w_pop;
    logic             w_read;
    logic             w_clr;
    logic             w_empty;
    logic             w_full;
    logic [PTR_W-1:0] w_top_ptr;
    logic [WIDTH-1:0] w_rd_val;

    // Command decode; unknown encodings fall through as no-ops.
    always_comb begin
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_read = 1'b0;
        w_clr  = 1'b0;
        case (i_op_cmd)
            `SC_PUS: w_push = 1'b1;
            `SC_POP: begin
                w_pop  = 1'b1;
                w_read = 1'b1;
            end
            `SC_TOP: w_read = 1'b1;
            `SC_CLR: w_clr  = 1'b1;
            default: ;
        endcase
    end

    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == SP_FULL);
    assign w_top_ptr = r_sp - SP_ONE;
    // An empty stack answers a read with the "no operator" code.
    assign w_rd_val  = w_empty ? WIDTH'(`CO_NO) : r_mem[w_top_ptr[AW-1:0]];

    // The bus is released except while the controller is reading from us.
    assign io_op_data = w_read ? w_rd_val : {WIDTH{1'bz}};

    assign o_op_empty = w_empty;
    assign o_op_full  = w_full;
    assign o_op_count = r_sp;
    assign o_op_err   = r_err;

    // Stack pointer and sticky error; the pointer saturates at both ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sp  <= '0;
            r_err <= 1'b0;
        end else if (w_clr) begin
            r_sp  <= '0;
            r_err <= 1'b0;
        end else if (w_push) begin
            if (!w_full) r_sp <= r_sp + SP_ONE;
            else         r_err <= 1'b1;
        end else if (w_pop) begin
            if (!w_empty) r_sp <= r_sp - SP_ONE;
            else          r_err <= 1'b1;
        end
    end

    // Entry storage; contents are not reset and not scrubbed on clear.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push && !w_full) begin
            r_mem[r_sp[AW-1:0]] <= io_op_data;
        end
    end

endmodule

// File: tb/tb_op_stack.sv
// Testbench for op_stack: directed scenarios plus random traffic checked
// against a queue-based reference model of the stack.

`ifndef CO_N
`define CO_N 4
`endif
`ifndef CO_NO
`define CO_NO 4'd0
`endif
`ifndef CO_AD
`define CO_AD 4'd1
`endif
`ifndef CO_SB
`define CO_SB 4'd2
`endif
`ifndef SC_N
`define SC_N 3
`endif
`ifndef SC_NON
`define SC_NON 3'd0
`endif
`ifndef SC_PUS
`define SC_PUS 3'd1
`endif
`ifndef SC_POP
`define SC_POP 3'd2
`endif
`ifndef SC_TOP
`define SC_TOP 3'd3
`endif
`ifndef SC_CLR
`define SC_CLR 3'd4
`endif

module tb_op_stack;

    localparam int W  = `CO_N;
    localparam int D  = 16;
    localparam int PW = 5;
    localparam logic [W-1:0] PULL = {W{1'b1}};

    logic             clk = 1'b0;
    logic             rst_n;
    logic [`SC_N-1:0] cmd;
    logic             tb_drv;
    logic [W-1:0]     tb_val;
    tri1  [W-1:0]     bus;
    wire              empty;
    wire              full;
    wire              err;
    wire  [PW-1:0]    count;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [W-1:0] q[$];
    bit           m_err;

    always #5 clk = ~clk;

    assign bus = tb_drv ? tb_val : {W{1'bz}};

    op_stack #(.WIDTH(W), .DEPTH(D), .PTR_W(PW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_op_cmd   (cmd),
        .io_op_data (bus),
        .o_op_empty (empty),
        .o_op_full  (full),
        .o_op_count (count),
        .o_op_err   (err)
    );

    function automatic logic [W-1:0] exp_bus(input logic [`SC_N-1:0] c, input logic [W-1:0] d);
        if (c == `SC_POP || c == `SC_TOP) return (q.size() > 0) ? q[q.size()-1] : `CO_NO;
        if (c == `SC_PUS) return d;
        return PULL;
    endfunction

    function automatic logic [PW+2:0] exp_stat();
        logic [PW-1:0] n;
        n = PW'(q.size());
        return {q.size() == 0, q.size() == D, m_err, n};
    endfunction

    function automatic void model_step(input logic [`SC_N-1:0] c, input logic [W-1:0] d);
        case (c)
            `SC_PUS: if (q.size() < D) q.push_back(d); else m_err = 1'b1;
            `SC_POP: if (q.size() > 0) void'(q.pop_back()); else m_err = 1'b1;
            `SC_CLR: begin q.delete(); m_err = 1'b0; end
            default: ;
        endcase
    endfunction

    // Present a command after the falling edge; bus settles 1 time unit later.
    task automatic drive(input logic [`SC_N-1:0] c, input logic [W-1:0] d);
        @(negedge clk);
        cmd    = c;
        tb_drv = (c == `SC_PUS);
        tb_val = d;
        #1;
    endtask

    // Apply the rising edge to DUT and model, then settle.
    task automatic tick();
        model_step(cmd, tb_val);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        cmd = `SC_NON; tb_drv = 1'b0;
    endtask

    task automatic test_reset();
        logic [PW+2:0] st;
        rst_n = 1'b0; cmd = `SC_NON; tb_drv = 1'b0; tb_val = '0;
        q.delete(); m_err = 1'b0;
        #12;
        st = {empty, full, err, count};
        total++; if (st !== exp_stat()) begin bad++; $display("FAIL reset_init: got %b want %b", st, exp_stat()); end
        total++; if (bus !== PULL) begin bad++; $display("FAIL reset_bus: got %h want %h", bus, PULL); end
        // Release reset together with a push; the push must take effect.
        @(negedge clk);
        rst_n = 1'b1; cmd = `SC_PUS; tb_drv = 1'b1; tb_val = 4'd7;
        tick();
        st = {empty, full, err, count};
        total++; if (st !== exp_stat()) begin bad++; $display("FAIL reset_release_push: got %b want %b", st, exp_stat()); end
        // Build sp=3 with err set, then assert reset mid-cycle.
        drive(`SC_PUS, 4'd3); tick();
        drive(`SC_PUS, 4'd5); tick();
        drive(`SC_CLR, '0); tick();
        drive(`SC_POP, '0); tick();
        for (int i = 0; i < 3; i++) begin drive(`SC_PUS, W'(i + 8)); tick(); end
        drive(`SC_TOP, '0);
        total++; if ({count, err} !== {PW'(3), 1'b1}) begin bad++; $display("FAIL reset_pre: got %0d/%b want 3/1", count, err); end
        #2;
        rst_n = 1'b0;
        q.delete(); m_err = 1'b0;
        #1;
        cmd = `SC_NON; tb_drv = 1'b0;
        #1;
        st = {empty, full, err, count};
        total++; if (st !== exp_stat()) begin bad++; $display("FAIL reset_mid: got %b want %b", st, exp_stat()); end
        total++; if (bus !== PULL) begin bad++; $display("FAIL reset_mid_bus: got %h want %h", bus, PULL); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lifo();
        logic [PW+2:0] st;
        drive(`SC_PUS, `CO_AD); tick();
        drive(`SC_PUS, `CO_SB); tick();
        drive(`SC_POP, '0);
        total++; if (bus !== `CO_SB) begin bad++; $display("FAIL lifo_pop1: got %h want %h", bus, `CO_SB); end
        tick();
        drive(`SC_POP, '0);
        total++; if (bus !== `CO_AD) begin bad++; $display("FAIL lifo_pop2: got %h want %h", bus, `CO_AD); end
        tick();
        st = {empty, full, err, count};
        total++; if (st !== {1'b1, 1'b0, 1'b0, PW'(0)}) begin bad++; $display("FAIL lifo_end: got %b want %b", st, {1'b1, 1'b0, 1'b0, PW'(0)}); end
    endtask

    task automatic test_top();
        drive(`SC_PUS, `CO_AD); tick();
        for (int i = 0; i < 3; i++) begin
            drive(`SC_TOP, '0);
            total++; if (bus !== `CO_AD) begin bad++; $display("FAIL top_bus%0d: got %h want %h", i, bus, `CO_AD); end
            tick();
            total++; if (count !== PW'(1)) begin bad++; $display("FAIL top_count%0d: got %0d want 1", i, count); end
        end
        drive(`SC_CLR, '0); tick();
    endtask

    task automatic test_overflow();
        logic [W-1:0] vals[D];
        logic [PW+2:0] st;
        for (int i = 0; i < D; i++) begin
            vals[i] = W'($urandom_range(0, 14));
            drive(`SC_PUS, vals[i]); tick();
        end
        st = {empty, full, err, count};
        total++; if (st !== {1'b0, 1'b1, 1'b0, PW'(D)}) begin bad++; $display("FAIL ovf_full: got %b want %b", st, {1'b0, 1'b1, 1'b0, PW'(D)}); end
        drive(`SC_PUS, ~vals[D-1]); tick();
        st = {empty, full, err, count};
        total++; if (st !== {1'b0, 1'b1, 1'b1, PW'(D)}) begin bad++; $display("FAIL ovf_push17: got %b want %b", st, {1'b0, 1'b1, 1'b1, PW'(D)}); end
        drive(`SC_POP, '0);
        total++; if (bus !== vals[D-1]) begin bad++; $display("FAIL ovf_pop: got %h want %h", bus, vals[D-1]); end
        tick();
        total++; if (count !== PW'(D-1)) begin bad++; $display("FAIL ovf_count: got %0d want %0d", count, D-1); end
    endtask

    task automatic test_underflow();
        logic [PW+2:0] st;
        drive(`SC_CLR, '0); tick();
        drive(`SC_POP, '0);
        total++; if (bus !== `CO_NO) begin bad++; $display("FAIL unf_bus: got %h want %h", bus, `CO_NO); end
        tick();
        st = {empty, full, err, count};
        total++; if (st !== {1'b1, 1'b0, 1'b1, PW'(0)}) begin bad++; $display("FAIL unf_state: got %b want %b", st, {1'b1, 1'b0, 1'b1, PW'(0)}); end
        drive(`SC_NON, '0); tick();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL unf_sticky: got %b want 1", err); end
        drive(`SC_CLR, '0); tick();
        st = {empty, full, err, count};
        total++; if (st !== {1'b1, 1'b0, 1'b0, PW'(0)}) begin bad++; $display("FAIL unf_clr: got %b want %b", st, {1'b1, 1'b0, 1'b0, PW'(0)}); end
    endtask

    task automatic test_undefined();
        drive(`SC_PUS, `CO_SB); tick();
        for (int c = 5; c < 8; c++) begin
            drive(`SC_N'(c), '0);
            total++; if (bus !== PULL) begin bad++; $display("FAIL undef_bus%0d: got %h want %h", c, bus, PULL); end
            tick();
            total++; if ({count, err} !== {PW'(1), 1'b0}) begin bad++; $display("FAIL undef_state%0d: got %0d/%b want 1/0", c, count, err); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v;
        for (int i = 0; i < 8; i++) begin
            v = W'($urandom);
            drive(`SC_PUS, v); tick();
            drive(`SC_POP, '0);
            total++; if (bus !== v) begin bad++; $display("FAIL b2b_%0d: got %h want %h", i, bus, v); end
            tick();
        end
        total++; if (count !== PW'(q.size())) begin bad++; $display("FAIL b2b_count: got %0d want %0d", count, q.size()); end
    endtask

    task automatic test_random();
        logic [`SC_N-1:0] c;
        logic [W-1:0]     d;
        logic [W-1:0]     eb;
        logic [PW+2:0]    st;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: c = `SC_PUS;
                4, 5, 6:    c = `SC_POP;
                7:          c = `SC_TOP;
                8:          c = ($urandom_range(0, 7) == 0) ? `SC_CLR : `SC_NON;
                default:    c = `SC_N'($urandom_range(5, 7));
            endcase
            d = W'($urandom);
            drive(c, d);
            eb = exp_bus(c, d);
            total++; if (bus !== eb) begin bad++; $display("FAIL rnd_bus[%0d] cmd=%0d: got %h want %h", i, c, bus, eb); end
            tick();
            st = {empty, full, err, count};
            total++; if (st !== exp_stat()) begin bad++; $display("FAIL rnd_stat[%0d] cmd=%0d: got %b want %b", i, c, st, exp_stat()); end
        end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_top();
        test_overflow();
        test_underflow();
        test_undefined();
        test_back_to_back();
        test_random();
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
